// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// owner constants and the widths of the latency and streak counters.
// No ports; imported by the arbiter top and its pick sub-module.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int CNT_W    = 4;
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory macro signals.
// slave  : arbiter view (requests and memory read data in; grants, responses, memory strobes out).
// master : requester/memory view, the mirror of slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  i_req_i;
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic                  i_gnt_o;
  logic                  i_rvalid_o;
  logic [DATA_WIDTH-1:0] i_rdata_o;

  logic                  d_req_i;
  logic                  d_we_i;
  logic [3:0]            d_be_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output i_req_i, i_addr_i,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output mem_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between fetch and data requests; zero latency.
// Data wins unless fetch is pending and the D streak is full; no grant while arb_en=0.
// Ports: i_req/d_req requests, streak_full guard, arb_en window; gnt_i/gnt_d one-hot (or zero) grants.
module mem_arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic streak_full,
  input  logic arb_en,
  output logic gnt_i,
  output logic gnt_d
);

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (arb_en) begin
      // Starvation guard: a full streak hands the slot to a waiting fetch.
      if (d_req && !(i_req && streak_full)) begin
        gnt_d = 1'b1;
      end else if (i_req) begin
        gnt_i = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (I) and data (D) requesters.
// Latency: grant at T, rvalid at T+MEM_LATENCY+1; one transaction in flight, new grant allowed in the rvalid cycle.
// Backpressure: requests are held until gnt; nothing is granted while a transaction waits on memory.
// Ports: clk, rst (sync, active-high), bus (slave modport: I port, D port, memory macro).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STREAK  = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0]    LAT_M1     = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [STREAK_W-1:0]   r_streak;
  logic                  r_owner;
  logic                  r_store;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  logic                  w_arb_en;
  logic                  w_streak_full;
  logic                  w_gnt_i;
  logic                  w_gnt_d;
  logic                  w_mem_we;
  logic [3:0]            w_mem_be;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_capture;

  // Reset gates arbitration so no grant escapes while rst is high.
  assign w_arb_en      = !rst && ((r_state == IDLE) || (r_state == RESP));
  assign w_streak_full = (r_streak == STREAK_MAX);
  assign w_capture     = (r_state == WAIT) && (r_cnt == '0);

  mem_arb_pick u_pick (
    .i_req       (bus.i_req_i),
    .d_req       (bus.d_req_i),
    .streak_full (w_streak_full),
    .arb_en      (w_arb_en),
    .gnt_i       (w_gnt_i),
    .gnt_d       (w_gnt_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_be    = 4'h0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;

    // Memory strobes are zero unless this cycle carries a grant.
    if (w_gnt_d) begin
      w_mem_we    = bus.d_we_i;
      w_mem_be    = bus.d_be_i;
      w_mem_addr  = bus.d_addr_i;
      w_mem_wdata = bus.d_wdata_i;
    end else if (w_gnt_i) begin
      w_mem_be    = 4'hF;
      w_mem_addr  = bus.i_addr_i;
    end

    case (r_state)
      IDLE:    if (w_gnt_i || w_gnt_d) w_state_nxt = WAIT;
      WAIT:    if (r_cnt == '0) w_state_nxt = RESP;
      RESP:    w_state_nxt = (w_gnt_i || w_gnt_d) ? WAIT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_streak  <= '0;
      r_owner   <= OWN_I;
      r_store   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_gnt_i || w_gnt_d) begin
        r_owner <= w_gnt_d ? OWN_D : OWN_I;
        r_store <= w_gnt_d && bus.d_we_i;
        r_cnt   <= LAT_M1;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // Streak only grows while fetch is actually waiting behind data.
      if (w_gnt_i) begin
        r_streak <= '0;
      end else if (w_gnt_d) begin
        if (!bus.i_req_i) begin
          r_streak <= '0;
        end else if (!w_streak_full) begin
          r_streak <= r_streak + 1'b1;
        end
      end

      // Stores complete without touching the load data register.
      if (w_capture) begin
        if (r_owner == OWN_I) begin
          r_i_rdata <= bus.mem_rdata_i;
        end else if (!r_store) begin
          r_d_rdata <= bus.mem_rdata_i;
        end
      end
    end
  end

  assign bus.i_gnt_o     = w_gnt_i;
  assign bus.d_gnt_o     = w_gnt_d;
  assign bus.i_rvalid_o  = !rst && (r_state == RESP) && (r_owner == OWN_I);
  assign bus.d_rvalid_o  = !rst && (r_state == RESP) && (r_owner == OWN_D);
  assign bus.i_rdata_o   = r_i_rdata;
  assign bus.d_rdata_o   = r_d_rdata;
  assign bus.mem_en_o    = w_gnt_i || w_gnt_d;
  assign bus.mem_we_o    = w_mem_we;
  assign bus.mem_be_o    = w_mem_be;
  assign bus.mem_addr_o  = w_mem_addr;
  assign bus.mem_wdata_o = w_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a_if ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b_if ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .MAX_STREAK(4)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave));
  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .MAX_STREAK(4)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave));

  // Memory contents; data only appears on the read bus in the exact valid cycle.
  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    case (addr)
      32'h10:  return 32'h00500093;
      32'h100: return 32'hDEADBEEF;
      32'h40:  return 32'h0BADF00D;
      default: return {addr[15:0], 16'hC0DE};
    endcase
  endfunction

  logic        a_pv = 1'b0;
  logic [31:0] a_pd = '0;
  always @(posedge clk) begin
    a_pv <= a_if.mem_en_o && !a_if.mem_we_o;
    a_pd <= mem_val(a_if.mem_addr_o);
  end
  assign a_if.mem_rdata_i = a_pv ? a_pd : 32'hBADBAD00;

  logic        b_pv [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] b_pd [3] = '{32'h0, 32'h0, 32'h0};
  always @(posedge clk) begin
    b_pv[0] <= b_if.mem_en_o && !b_if.mem_we_o;
    b_pd[0] <= mem_val(b_if.mem_addr_o);
    for (int k = 1; k < 3; k++) begin
      b_pv[k] <= b_pv[k-1];
      b_pd[k] <= b_pd[k-1];
    end
  end
  assign b_if.mem_rdata_i = b_pv[2] ? b_pd[2] : 32'hBADBAD00;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_if.i_req_i = 0; a_if.i_addr_i = 0; a_if.d_req_i = 1; a_if.d_we_i = 0;
    a_if.d_be_i = 4'hF; a_if.d_addr_i = 32'h100; a_if.d_wdata_i = 0;
    b_if.i_req_i = 0; b_if.i_addr_i = 0; b_if.d_req_i = 0; b_if.d_we_i = 0;
    b_if.d_be_i = 4'hF; b_if.d_addr_i = 0; b_if.d_wdata_i = 0;
    rst = 1;
    cyc(); cyc(); samp();
    checks++; if (a_if.d_gnt_o !== 1'b0) begin failures++; $display("FAIL rst_d_gnt: got %b want 0", a_if.d_gnt_o); end
    checks++; if (a_if.mem_en_o !== 1'b0 || a_if.mem_we_o !== 1'b0) begin failures++; $display("FAIL rst_mem_en_we: got %b%b want 00", a_if.mem_en_o, a_if.mem_we_o); end
    checks++; if (a_if.i_rvalid_o !== 1'b0 || a_if.d_rvalid_o !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %b%b want 00", a_if.i_rvalid_o, a_if.d_rvalid_o); end
    checks++; if (a_if.i_rdata_o !== 32'h0 || a_if.d_rdata_o !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h %h want 0 0", a_if.i_rdata_o, a_if.d_rdata_o); end
    checks++; if (b_if.mem_en_o !== 1'b0 || b_if.i_gnt_o !== 1'b0) begin failures++; $display("FAIL rst_b_idle: got en=%b gnt=%b want 0 0", b_if.mem_en_o, b_if.i_gnt_o); end
    cyc(); a_if.d_req_i = 0; rst = 0;
  endtask

  task automatic test_fetch();
    cyc(); a_if.i_req_i = 1; a_if.i_addr_i = 32'h10; samp();
    checks++; if (a_if.i_gnt_o !== 1'b1 || a_if.mem_en_o !== 1'b1) begin failures++; $display("FAIL fetch_gnt: got gnt=%b en=%b want 1 1", a_if.i_gnt_o, a_if.mem_en_o); end
    checks++; if (a_if.mem_addr_o !== 32'h10 || a_if.mem_we_o !== 1'b0 || a_if.mem_be_o !== 4'hF) begin failures++; $display("FAIL fetch_bus: got addr=%h we=%b be=%h want 10 0 f", a_if.mem_addr_o, a_if.mem_we_o, a_if.mem_be_o); end
    cyc(); a_if.i_req_i = 0; samp();
    checks++; if (a_if.i_gnt_o !== 1'b0 || a_if.mem_en_o !== 1'b0 || a_if.i_rvalid_o !== 1'b0) begin failures++; $display("FAIL fetch_wait: got gnt=%b en=%b rv=%b want 000", a_if.i_gnt_o, a_if.mem_en_o, a_if.i_rvalid_o); end
    cyc(); samp();
    checks++; if (a_if.i_rvalid_o !== 1'b1 || a_if.d_rvalid_o !== 1'b0) begin failures++; $display("FAIL fetch_rvalid: got i=%b d=%b want 1 0", a_if.i_rvalid_o, a_if.d_rvalid_o); end
    checks++; if (a_if.i_rdata_o !== 32'h00500093) begin failures++; $display("FAIL fetch_rdata: got %h want 00500093", a_if.i_rdata_o); end
    cyc(); samp();
    checks++; if (a_if.i_rvalid_o !== 1'b0 || a_if.i_rdata_o !== 32'h00500093) begin failures++; $display("FAIL fetch_hold: got rv=%b data=%h want 0 00500093", a_if.i_rvalid_o, a_if.i_rdata_o); end
  endtask

  task automatic test_back_to_back();
    cyc(); a_if.i_req_i = 1; a_if.i_addr_i = 32'h20;
    a_if.d_req_i = 1; a_if.d_we_i = 0; a_if.d_be_i = 4'hF; a_if.d_addr_i = 32'h100; samp();
    checks++; if (a_if.d_gnt_o !== 1'b1 || a_if.i_gnt_o !== 1'b0 || a_if.mem_addr_o !== 32'h100) begin failures++; $display("FAIL b2b_d_first: got d=%b i=%b addr=%h want 1 0 100", a_if.d_gnt_o, a_if.i_gnt_o, a_if.mem_addr_o); end
    cyc(); a_if.d_req_i = 0; samp();
    checks++; if (a_if.i_gnt_o !== 1'b0 || a_if.d_gnt_o !== 1'b0) begin failures++; $display("FAIL b2b_wait_nogrant: got i=%b d=%b want 0 0", a_if.i_gnt_o, a_if.d_gnt_o); end
    cyc(); samp();
    checks++; if (a_if.d_rvalid_o !== 1'b1 || a_if.d_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_load: got rv=%b data=%h want 1 deadbeef", a_if.d_rvalid_o, a_if.d_rdata_o); end
    checks++; if (a_if.i_gnt_o !== 1'b1 || a_if.mem_addr_o !== 32'h20 || a_if.i_rvalid_o !== 1'b0) begin failures++; $display("FAIL b2b_i_in_resp: got gnt=%b addr=%h rv=%b want 1 20 0", a_if.i_gnt_o, a_if.mem_addr_o, a_if.i_rvalid_o); end
    cyc(); a_if.i_req_i = 0; cyc(); samp();
    checks++; if (a_if.i_rvalid_o !== 1'b1 || a_if.i_rdata_o !== 32'h0020C0DE || a_if.d_rvalid_o !== 1'b0) begin failures++; $display("FAIL b2b_fetch: got rv=%b data=%h drv=%b want 1 0020c0de 0", a_if.i_rvalid_o, a_if.i_rdata_o, a_if.d_rvalid_o); end
  endtask

  task automatic test_store();
    cyc(); a_if.d_req_i = 1; a_if.d_we_i = 1; a_if.d_be_i = 4'b0011;
    a_if.d_addr_i = 32'h200; a_if.d_wdata_i = 32'h1234ABCD; samp();
    checks++; if (a_if.d_gnt_o !== 1'b1 || a_if.mem_we_o !== 1'b1 || a_if.mem_be_o !== 4'b0011) begin failures++; $display("FAIL store_ctl: got gnt=%b we=%b be=%b want 1 1 0011", a_if.d_gnt_o, a_if.mem_we_o, a_if.mem_be_o); end
    checks++; if (a_if.mem_addr_o !== 32'h200 || a_if.mem_wdata_o !== 32'h1234ABCD) begin failures++; $display("FAIL store_bus: got addr=%h wdata=%h want 200 1234abcd", a_if.mem_addr_o, a_if.mem_wdata_o); end
    cyc(); a_if.d_req_i = 0; a_if.d_we_i = 0; samp();
    checks++; if (a_if.mem_we_o !== 1'b0 || a_if.mem_be_o !== 4'h0 || a_if.mem_wdata_o !== 32'h0) begin failures++; $display("FAIL store_idle_bus: got we=%b be=%h wdata=%h want 0 0 0", a_if.mem_we_o, a_if.mem_be_o, a_if.mem_wdata_o); end
    cyc(); samp();
    checks++; if (a_if.d_rvalid_o !== 1'b1 || a_if.d_rdata_o !== 32'hDEADBEEF || a_if.i_rvalid_o !== 1'b0) begin failures++; $display("FAIL store_resp: got rv=%b data=%h irv=%b want 1 deadbeef 0", a_if.d_rvalid_o, a_if.d_rdata_o, a_if.i_rvalid_o); end
  endtask

  task automatic test_streak();
    logic exp_d;
    cyc(); a_if.i_req_i = 1; a_if.i_addr_i = 32'h30;
    a_if.d_req_i = 1; a_if.d_we_i = 0; a_if.d_be_i = 4'hF; a_if.d_addr_i = 32'h104;
    for (int k = 0; k < 10; k++) begin
      exp_d = !(k == 4 || k == 9);
      samp();
      checks++; if (a_if.d_gnt_o !== exp_d || a_if.i_gnt_o !== !exp_d) begin failures++; $display("FAIL streak_grant_%0d: got d=%b i=%b want d=%b i=%b", k, a_if.d_gnt_o, a_if.i_gnt_o, exp_d, !exp_d); end
      cyc(); samp();
      checks++; if (a_if.d_gnt_o !== 1'b0 || a_if.i_gnt_o !== 1'b0) begin failures++; $display("FAIL streak_gap_%0d: got d=%b i=%b want 0 0", k, a_if.d_gnt_o, a_if.i_gnt_o); end
      if (k == 9) begin a_if.i_req_i = 0; a_if.d_req_i = 0; end
      cyc();
    end
    cyc();
  endtask

  task automatic test_latency3();
    cyc(); b_if.i_req_i = 1; b_if.i_addr_i = 32'h40; samp();
    checks++; if (b_if.i_gnt_o !== 1'b1 || b_if.mem_en_o !== 1'b1) begin failures++; $display("FAIL lat3_gnt: got gnt=%b en=%b want 1 1", b_if.i_gnt_o, b_if.mem_en_o); end
    for (int j = 1; j <= 3; j++) begin
      cyc();
      if (j == 1) begin b_if.i_req_i = 0; b_if.d_req_i = 1; b_if.d_we_i = 0; b_if.d_addr_i = 32'h100; end
      samp();
      checks++; if (b_if.mem_en_o !== 1'b0 || b_if.d_gnt_o !== 1'b0 || b_if.i_rvalid_o !== 1'b0) begin failures++; $display("FAIL lat3_wait_%0d: got en=%b dgnt=%b rv=%b want 000", j, b_if.mem_en_o, b_if.d_gnt_o, b_if.i_rvalid_o); end
    end
    cyc(); samp();
    checks++; if (b_if.i_rvalid_o !== 1'b1 || b_if.i_rdata_o !== 32'h0BADF00D) begin failures++; $display("FAIL lat3_rvalid: got rv=%b data=%h want 1 0badf00d", b_if.i_rvalid_o, b_if.i_rdata_o); end
    checks++; if (b_if.d_gnt_o !== 1'b1 || b_if.mem_addr_o !== 32'h100) begin failures++; $display("FAIL lat3_d_in_resp: got gnt=%b addr=%h want 1 100", b_if.d_gnt_o, b_if.mem_addr_o); end
    cyc(); b_if.d_req_i = 0;
    repeat (3) cyc();
    samp();
    checks++; if (b_if.d_rvalid_o !== 1'b1 || b_if.d_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL lat3_load: got rv=%b data=%h want 1 deadbeef", b_if.d_rvalid_o, b_if.d_rdata_o); end
    cyc();
  endtask

  task automatic test_midflight_reset();
    cyc(); a_if.d_req_i = 1; a_if.d_we_i = 0; a_if.d_be_i = 4'hF; a_if.d_addr_i = 32'h104; samp();
    checks++; if (a_if.d_gnt_o !== 1'b1) begin failures++; $display("FAIL mrst_gnt: got %b want 1", a_if.d_gnt_o); end
    cyc(); a_if.d_req_i = 0; rst = 1; samp();
    checks++; if (a_if.d_gnt_o !== 1'b0 || a_if.i_gnt_o !== 1'b0 || a_if.mem_en_o !== 1'b0 || a_if.mem_we_o !== 1'b0) begin failures++; $display("FAIL mrst_outputs: got dg=%b ig=%b en=%b we=%b want 0000", a_if.d_gnt_o, a_if.i_gnt_o, a_if.mem_en_o, a_if.mem_we_o); end
    checks++; if (a_if.d_rvalid_o !== 1'b0 || a_if.i_rvalid_o !== 1'b0) begin failures++; $display("FAIL mrst_rvalid: got d=%b i=%b want 0 0", a_if.d_rvalid_o, a_if.i_rvalid_o); end
    cyc(); rst = 0; a_if.d_req_i = 1; a_if.d_addr_i = 32'h108; samp();
    checks++; if (a_if.d_rvalid_o !== 1'b0 || a_if.d_rdata_o !== 32'h0 || a_if.i_rdata_o !== 32'h0) begin failures++; $display("FAIL mrst_dropped: got rv=%b d=%h i=%h want 0 0 0", a_if.d_rvalid_o, a_if.d_rdata_o, a_if.i_rdata_o); end
    checks++; if (a_if.d_gnt_o !== 1'b1 || a_if.mem_addr_o !== 32'h108) begin failures++; $display("FAIL mrst_fresh_gnt: got gnt=%b addr=%h want 1 108", a_if.d_gnt_o, a_if.mem_addr_o); end
    cyc(); a_if.d_req_i = 0; samp();
    checks++; if (a_if.d_rvalid_o !== 1'b0) begin failures++; $display("FAIL mrst_wait: got rv=%b want 0", a_if.d_rvalid_o); end
    cyc(); samp();
    checks++; if (a_if.d_rvalid_o !== 1'b1 || a_if.d_rdata_o !== 32'h0108C0DE) begin failures++; $display("FAIL mrst_fresh_load: got rv=%b data=%h want 1 0108c0de", a_if.d_rvalid_o, a_if.d_rdata_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000ns, required finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_store();
    test_streak();
    test_latency3();
    test_midflight_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the instruction-fetch requester (port I) and the data load/store requester (port D).
- Sits between the fetch/memory-access pipeline stages and a unified memory macro.
- Sequences one outstanding transaction at a time.
- Data port has priority, with a starvation guard for fetch.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width (must be 32; byte enables are 4 bits).
- MEM_LATENCY, 1, cycles from mem_en_o to valid mem_rdata_i; legal range 1..15.
- MAX_STREAK, 4, max consecutive D grants while i_req_i is pending; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_req_i  in  1  fetch request, held with i_addr_i until i_gnt_o
- i_addr_i  in  ADDR_WIDTH  fetch address
- i_gnt_o  out  1  fetch request accepted this cycle
- i_rvalid_o  out  1  one-cycle pulse, i_rdata_o valid
- i_rdata_o  out  DATA_WIDTH  fetched word
- d_req_i  in  1  data request, held with payload until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_be_i  in  4  store byte enables
- d_addr_i  in  ADDR_WIDTH  data address
- d_wdata_i  in  DATA_WIDTH  store data
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  one-cycle pulse; load data valid, or store complete
- d_rdata_o  out  DATA_WIDTH  load data
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en_o

Behaviour:
- Reset (synchronous, rst=1):
  - State goes to IDLE; cnt, streak and owner clear.
  - All gnt, rvalid and mem_en/we outputs are 0; rdata registers are 0.
  - An in-flight transaction is dropped: no rvalid, late memory data ignored.
- States:
  - IDLE: arbitrating.
  - WAIT: cnt counts MEM_LATENCY-1 down to 0.
  - RESP: rvalid pulse; arbitration is allowed again.
- Arbitration (combinational, only in IDLE or RESP):
  - If d_req_i, grant D, unless i_req_i=1 and streak==MAX_STREAK, in which case grant I.
  - Otherwise, if i_req_i, grant I.
  - At most one gnt per cycle.
- Grant cycle T:
  - gnt_o=1 and mem_en_o=1, with mem_we/be/addr/wdata muxed combinationally from the winner.
  - Port I always drives mem_we_o=0 and mem_be_o=4'hF.
  - mem_we_o, mem_be_o and mem_wdata_o are 0 whenever mem_en_o=0.
  - owner is registered; the FSM moves to WAIT with cnt=MEM_LATENCY-1.
- WAIT: when cnt==0, capture mem_rdata_i into the owner's rdata register (loads and fetches only) and go to RESP.
- RESP (cycle T+MEM_LATENCY+1):
  - owner's rvalid_o=1 for exactly one cycle; the other port's rvalid_o=0.
  - Stores: d_rvalid_o pulses and d_rdata_o holds its previous value.
  - A new grant in the same cycle goes to WAIT; otherwise go to IDLE.
- Throughput: one transaction per MEM_LATENCY+1 cycles.
- rdata outputs hold their value until the next capture for the same port.
- Streak counter:
  - Increments (saturating at MAX_STREAK) on a D grant while i_req_i=1.
  - Clears on any I grant, or on a D grant with i_req_i=0.
- Requests seen in WAIT are not granted; requesters keep them held.
- Dropping req before gnt is illegal; no checking is required.
- Simultaneous rvalid and new gnt to the same port is legal and expected.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - owner constants: OWN_I=1'b0, OWN_D=1'b1;
  - width localparams for cnt and streak (4 bits).
- One sub-module, mem_arb_pick, is natural: the combinational pick logic (inputs: i_req, d_req, streak_full, arb_en; outputs: gnt_i, gnt_d).
- FSM, counters and datapath muxing stay in mem_port_arbiter.

Test Plan:
1. MEM_LATENCY=1, I-only fetch of addr 0x10, memory returns 0x00500093 -> i_gnt_o at T, mem_addr_o=0x10 at T, i_rvalid_o at T+2 with i_rdata_o=0x00500093.
2. i_req_i and d_req_i both high, load addr 0x100 returning 0xDEADBEEF -> d_gnt_o first, d_rdata_o=0xDEADBEEF at T+2; i_gnt_o at T+2, the RESP cycle (back-to-back).
3. Store d_be_i=4'b0011, d_wdata_i=0x1234ABCD, addr 0x200 -> mem_we_o=1, mem_be_o=0011; d_rvalid_o at T+2; d_rdata_o unchanged.
4. MAX_STREAK=4, d_req_i and i_req_i held high -> grant sequence D,D,D,D,I,D,D,D,D,I; streak clears after each I grant.
5. MEM_LATENCY=3, single fetch -> mem_en_o high for one cycle only, i_rvalid_o at T+4, no grants at T+1..T+3 despite a pending d_req_i.
6. rst=1 at T+1 of an in-flight load -> IDLE next cycle, no d_rvalid_o ever; all outputs 0; a fresh request is granted the first cycle after rst deasserts.
